// File: rtl/gpu_pixel_fetcher.sv
// rtl/gpu_pixel_fetcher.sv - display-timed reader of the GPU read FIFO with optional 2x2 line-buffer scaling
// Build option: define UNDERFLOW_CNT_EN to keep the saturating underflow_cnt counter.

module gpu_pixel_fetcher #(
  parameter int         SRC_W       = 320,
  parameter int         SRC_H       = 240,
  parameter logic [7:0] UNDERFLOW_C = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_tick,
  input  logic [11:0] h_count,
  input  logic [11:0] v_count,
  input  logic        vsync,
  input  logic        halfRes,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  output logic        sync_err,
  output logic [15:0] underflow_cnt
);
  localparam int          XW    = $clog2(SRC_W);
  localparam logic [16:0] TOTAL = 17'(SRC_W * SRC_H);

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DRAIN} state_t;
  typedef enum logic [1:0] {SEL_HOLD, SEL_FIFO, SEL_LB, SEL_UNDER} sel_t;

  state_t        state, state_nx;
  sel_t          sel;
  logic          vsync_q, half_q, vs_fall, in_active, fetch_row, fetch_col;
  logic          tick_act, need_pop, can_pop;
  logic [11:0]   w_act, h_act;
  logic [XW-1:0] src_x, wr_addr;
  logic [16:0]   pop_count;
  logic [7:0]    pix_hold, lb_rdata;
  logic [7:0]    linebuf [SRC_W];

  assign vs_fall   = vsync_q & ~vsync;
  assign w_act     = half_q ? 12'(2 * SRC_W) : 12'(SRC_W);
  assign h_act     = half_q ? 12'(2 * SRC_H) : 12'(SRC_H);
  assign in_active = (h_count < w_act) && (v_count < h_act);
  assign fetch_row = !half_q || !v_count[0];
  assign fetch_col = !half_q || !h_count[0];
  assign src_x     = half_q ? h_count[XW:1] : h_count[XW-1:0];
  assign tick_act  = (state == ACTIVE) && pix_tick && in_active;
  assign need_pop  = tick_act && fetch_row && fetch_col;
  assign can_pop   = !fifo_empty && (pop_count < TOTAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_FRAME;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (vs_fall) begin
      state_nx = ACTIVE;
    end else begin
      case (state)
        ACTIVE:  if (v_count == h_act) state_nx = DRAIN;
        DRAIN:   if (pop_count == TOTAL) state_nx = WAIT_FRAME;
        default: ;
      endcase
    end
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    case (state)
      ACTIVE:  fifo_rd_en = need_pop && can_pop;
      DRAIN:   fifo_rd_en = !vs_fall && can_pop;
      default: ;
    endcase
  end

  // Output mux sits after the register stage so FIFO/RAM data lands in the strobe cycle.
  always_comb begin
    pixel_data = pix_hold;
    case (sel)
      SEL_FIFO:  pixel_data = fifo_rd_data;
      SEL_LB:    pixel_data = lb_rdata;
      SEL_UNDER: pixel_data = UNDERFLOW_C;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 1'b0;
      half_q      <= 1'b0;
      pop_count   <= '0;
      sync_err    <= 1'b0;
      pixel_valid <= 1'b0;
      sel         <= SEL_HOLD;
      wr_addr     <= '0;
      pix_hold    <= '0;
    end else begin
      vsync_q     <= vsync;
      pixel_valid <= tick_act;
      pix_hold    <= pixel_data;
      sel         <= SEL_HOLD;
      if (vs_fall) begin
        half_q    <= halfRes;
        pop_count <= '0;
        if (state == DRAIN) sync_err <= 1'b1;
      end else if (fifo_rd_en) begin
        pop_count <= pop_count + 17'd1;
      end
      if (tick_act) begin
        wr_addr <= src_x;
        if (need_pop)       sel <= can_pop ? SEL_FIFO : SEL_UNDER;
        else if (!fetch_row) sel <= SEL_LB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sel == SEL_FIFO || sel == SEL_UNDER) linebuf[wr_addr] <= pixel_data;
    if (tick_act && !fetch_row) lb_rdata <= linebuf[src_x];
  end

`ifdef UNDERFLOW_CNT_EN
  logic [15:0] und_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        und_q <= '0;
    else if (need_pop && !can_pop && und_q != 16'hFFFF)  und_q <= und_q + 16'd1;
  end

  assign underflow_cnt = und_q;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_gpu_pixel_fetcher.sv
// tb/tb_gpu_pixel_fetcher.sv - randomized frame-level bench for gpu_pixel_fetcher against an image/queue model
module tb_gpu_pixel_fetcher;
  localparam int SW = 8, SH = 4, TOT = SW * SH;

  logic        clk = 1'b0;
  logic        reset_n, pix_tick, vsync, halfRes, force_empty, fifo_empty;
  logic        fifo_rd_en, pixel_valid, sync_err;
  logic [11:0] h_count, v_count;
  logic [7:0]  fifo_rd_data, pixel_data;
  logic [15:0] underflow_cnt;

  logic [7:0] fmem [1024];
  int wr_ptr = 0, rd_ptr = 0, pop_total = 0, pop_empty_err = 0;
  logic [7:0] obs_q[$], exp_q[$], mq[$];
  logic [7:0] img [SH][SW];
  int n_checks = 0, n_pass = 0, m_und = 0, m_frame_pops = 0;
  bit m_sync = 0, m_in_drain = 0;

  gpu_pixel_fetcher #(.SRC_W(SW), .SRC_H(SH), .UNDERFLOW_C(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .pix_tick(pix_tick), .h_count(h_count), .v_count(v_count),
    .vsync(vsync), .halfRes(halfRes), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .sync_err(sync_err), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) pop_empty_err <= pop_empty_err + 1;
      fifo_rd_data <= fmem[rd_ptr % 1024];
      rd_ptr       <= rd_ptr + 1;
      pop_total    <= pop_total + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pixel_valid) obs_q.push_back(pixel_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic compare_pixels();
    check_eq("pixel_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq($sformatf("pixel[%0d]", i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input bit mode, input int extra, input int uf_line, input int uf_col,
                           input int uf_n, input bit toggle, input int rst_line, input bit underload);
    int n, sx, sy, wact, hact, pops_start, pops_rst;
    bit aborted, fe, frow, fcol;
    logic [7:0] val, b;
    logic [31:0] exp_und;
    aborted = 0;
    pops_rst = 0;
    @(negedge clk);
    halfRes = mode; vsync = 1'b1; v_count = 12'd100; h_count = 12'd0;
    repeat (2) @(negedge clk);
    if (m_in_drain && m_frame_pops < TOT) m_sync = 1;
    vsync = 1'b0;
    @(negedge clk);
    check_eq("sync_err", sync_err, m_sync);
    pops_start = pop_total;
    m_frame_pops = 0;
    m_in_drain = 0;
    n = underload ? TOT - 3 - mq.size() : TOT + extra;
    if (n < 0) n = 0;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      fmem[wr_ptr % 1024] = b;
      wr_ptr++;
      mq.push_back(b);
    end
    wact = mode ? 2 * SW : SW;
    hact = mode ? 2 * SH : SH;
    for (int v = 0; v < 2 * SH + 2; v++) begin
      for (int h = 0; h < 2 * SW + 2; h++) begin
        if (toggle && v == 2 && h == 0) halfRes = ~mode;
        if (rst_line >= 0 && v == rst_line && h == 0) begin
          compare_pixels();
          #2 reset_n = 1'b0;
          #1;
          check_eq("rst_pixel_data", pixel_data, 0);
          check_eq("rst_pixel_valid", pixel_valid, 0);
          check_eq("rst_fifo_rd_en", fifo_rd_en, 0);
          check_eq("rst_sync_err", sync_err, 0);
          check_eq("rst_underflow_cnt", underflow_cnt, 0);
          @(negedge clk);
          reset_n = 1'b1;
          aborted = 1; m_und = 0; m_sync = 0;
          pops_rst = pop_total;
        end
        if (!aborted && !m_in_drain && v == hact) begin
          m_in_drain = 1;
          while (m_frame_pops < TOT && mq.size() > 0) begin
            void'(mq.pop_front());
            m_frame_pops++;
          end
        end
        fe = (v == uf_line) && (h >= uf_col) && (h < uf_col + uf_n);
        v_count = 12'(v); h_count = 12'(h); force_empty = fe; pix_tick = 1'b1;
        if (!aborted && v < hact && h < wact) begin
          sx = mode ? h / 2 : h;
          sy = mode ? v / 2 : v;
          frow = !mode || (v % 2 == 0);
          fcol = !mode || (h % 2 == 0);
          if (frow && fcol) begin
            if (fe || mq.size() == 0 || m_frame_pops >= TOT) begin
              val = 8'h00;
              m_und++;
            end else begin
              val = mq.pop_front();
              m_frame_pops++;
            end
            img[sy][sx] = val;
          end
          exp_q.push_back(img[sy][sx]);
        end
        @(negedge clk);
        pix_tick = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    force_empty = 1'b0;
    repeat (40) @(negedge clk);
    compare_pixels();
    if (aborted) check_eq("pops_after_reset", pop_total - pops_rst, 0);
    else         check_eq("frame_pops", pop_total - pops_start, m_frame_pops);
    check_eq("pop_on_empty", pop_empty_err, 0);
`ifdef UNDERFLOW_CNT_EN
    exp_und = m_und;
`else
    exp_und = 0;
`endif
    check_eq("underflow_cnt", underflow_cnt, exp_und);
  endtask

  initial begin
    reset_n = 1'b0; pix_tick = 1'b0; vsync = 1'b0; halfRes = 1'b0; force_empty = 1'b0;
    h_count = '0; v_count = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_pixel_data", pixel_data, 0);
    check_eq("reset_pixel_valid", pixel_valid, 0);
    check_eq("reset_fifo_rd_en", fifo_rd_en, 0);
    check_eq("reset_sync_err", sync_err, 0);
    check_eq("reset_underflow_cnt", underflow_cnt, 0);
    reset_n = 1'b1;

    run_frame(1'b0, 2, -1, 0, 0, 1'b0, -1, 1'b0);
    run_frame(1'b1, 1, -1, 0, 0, 1'b0, -1, 1'b0);
    run_frame(1'b0, 1, 2, 2, 5, 1'b0, -1, 1'b0);
    run_frame(1'b1, 0, -1, 0, 0, 1'b1, -1, 1'b0);
    run_frame(1'($urandom_range(0, 1)), 0, -1, 0, 0, 1'b0, -1, 1'b1);
    run_frame(1'b1, 2, -1, 0, 0, 1'b0, 3, 1'b0);
    run_frame(1'b0, 1, -1, 0, 0, 1'b0, -1, 1'b0);
    for (int f = 0; f < 3; f++)
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2 * SH - 1)),
                int'($urandom_range(0, SW)), int'($urandom_range(1, 4)), 1'b0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
